// File: rtl/yacc_pkg.sv
// Shared constants and types for the YACC compressed-cache fill path.
// The cache-update stage imports this same package to decode CF and address fields.
package yacc_pkg;

    localparam int BEAT_W         = 64;
    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_W         = BEAT_W * BEATS_PER_LINE;

    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 11;
    localparam int IDX_MSB = 10;
    localparam int IDX_LSB = 8;
    localparam int BID_MSB = 7;
    localparam int BID_LSB = 6;

    localparam int TAG_W = TAG_MSB - TAG_LSB + 1;
    localparam int IDX_W = IDX_MSB - IDX_LSB + 1;
    localparam int BID_W = BID_MSB - BID_LSB + 1;

    typedef enum logic [1:0] {
        CF_NONE    = 2'b00,
        CF_HALF    = 2'b01,
        CF_QUARTER = 2'b10,
        CF_RSVD    = 2'b11
    } cf_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } fill_state_t;

endpackage

// File: rtl/fill_line_classifier_if.sv
// Beat-in / line-out handshake bundle between memory, fill classifier and cache update.
// master = memory/downstream side, slave = the classifier.
interface fill_line_classifier_if
    import yacc_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 512,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [BEAT_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [LINE_W-1:0] out_data;
    logic [1:0]        out_cf;
    logic [TAG_W-1:0]  out_tag;
    logic [IDX_W-1:0]  out_index;
    logic [BID_W-1:0]  out_blockid;

    modport master (
        output in_valid, in_addr, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cf, out_tag, out_index, out_blockid
    );

    modport slave (
        input  in_valid, in_addr, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cf, out_tag, out_index, out_blockid
    );

endinterface

// File: rtl/line_cf_detect.sv
// Streaming zero-region tracker: decides the compression factor as beats arrive.
// cf reflects the flags including the beat presented this cycle.
module line_cf_detect
    import yacc_pkg::*;
#(
    parameter int BEAT_W = 64
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [BEAT_W-1:0] beat_data,
    input  logic [2:0]        beat_idx,
    input  logic              accept,
    input  logic              clear,
    output cf_t               cf
);

    logic nz_mid_reg, nz_mid_next;
    logic nz_hi_reg,  nz_hi_next;
    logic beat_nz;

    always_comb begin
        beat_nz     = |beat_data;
        nz_mid_next = nz_mid_reg;
        nz_hi_next  = nz_hi_reg;
        if (clear) begin
            nz_mid_next = 1'b0;
            nz_hi_next  = 1'b0;
        end else if (accept) begin
            // beats 2-3 cover bits [255:128], beats 4-7 cover [511:256]
            if (beat_idx == 3'd2 || beat_idx == 3'd3)
                nz_mid_next = nz_mid_reg | beat_nz;
            if (beat_idx[2])
                nz_hi_next = nz_hi_reg | beat_nz;
        end
        cf = nz_hi_next ? CF_NONE : (nz_mid_next ? CF_HALF : CF_QUARTER);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            nz_mid_reg <= 1'b0;
            nz_hi_reg  <= 1'b0;
        end else begin
            nz_mid_reg <= nz_mid_next;
            nz_hi_reg  <= nz_hi_next;
        end
    end

endmodule

// File: rtl/fill_line_classifier.sv
// Memory-fill front end: assembles 8 beats into a line, classifies its CF,
// splits the miss address and presents everything over a valid/ready handshake.
module fill_line_classifier
    import yacc_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int LINE_W = 512,
    parameter int ADDR_W = 32
)(
    input  logic        clock,
    input  logic        reset_n,
    fill_line_classifier_if.slave bus,
    output logic        proto_err,
    output logic [31:0] cnt_cf0,
    output logic [31:0] cnt_cf1,
    output logic [31:0] cnt_cf2
);

    fill_state_t       state_reg, state_next;
    logic [2:0]        beat_cnt_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [BID_W-1:0]  bid_reg;
    cf_t               cf_reg;
    cf_t               cf_det;
    logic              proto_err_reg;
    logic [31:0]       cnt_vec [3];

    logic              accept;
    logic              last_slot;
    logic              handshake;
    logic [ADDR_W-1:0] addr_beat;
    logic [BID_LSB-1:0] addr_unused;

    assign accept      = bus.in_valid && (state_reg == COLLECT);
    assign last_slot   = (beat_cnt_reg == 3'(BEATS_PER_LINE - 1));
    assign handshake   = (state_reg == HOLD) && bus.out_ready;
    assign addr_beat   = bus.in_addr;
    assign addr_unused = addr_beat[BID_LSB-1:0];

    // in_ready and out_valid depend only on the state register, never on out_ready
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            COLLECT: begin
                bus.in_ready = 1'b1;
                if (accept && last_slot)
                    state_next = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            state_reg <= COLLECT;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            beat_cnt_reg  <= '0;
            tag_reg       <= '0;
            idx_reg       <= '0;
            bid_reg       <= '0;
            cf_reg        <= CF_NONE;
            proto_err_reg <= 1'b0;
        end else begin
            // in_last must coincide exactly with the final slot
            proto_err_reg <= accept && (bus.in_last != last_slot);
            if (accept) begin
                if (beat_cnt_reg == 3'd0) begin
                    tag_reg <= addr_beat[TAG_MSB:TAG_LSB];
                    idx_reg <= addr_beat[IDX_MSB:IDX_LSB];
                    bid_reg <= addr_beat[BID_MSB:BID_LSB];
                end
                if (last_slot) begin
                    cf_reg       <= cf_det;
                    beat_cnt_reg <= '0;
                end else if (bus.in_last) begin
                    beat_cnt_reg <= '0;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 3'd1;
                end
            end
        end
    end

    line_cf_detect #(
        .BEAT_W (BEAT_W)
    ) u_cf_detect (
        .clock     (clock),
        .reset_n   (reset_n),
        .beat_data (bus.in_data),
        .beat_idx  (beat_cnt_reg),
        .accept    (accept),
        .clear     (accept && (beat_cnt_reg == 3'd0)),
        .cf        (cf_det)
    );

    // Line slots are only written while collecting, so they hold steady in HOLD.
    for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_slot
        logic [BEAT_W-1:0] slot_reg;

        always_ff @(posedge clock) begin
            if (!reset_n)
                slot_reg <= '0;
            else if (accept && beat_cnt_reg == 3'(gi))
                slot_reg <= bus.in_data;
        end

        assign bus.out_data[gi*BEAT_W +: BEAT_W] = slot_reg;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [31:0] cnt_reg;

        always_ff @(posedge clock) begin
            if (!reset_n)
                cnt_reg <= '0;
            else if (handshake && cf_reg == cf_t'(gi) && cnt_reg != 32'hFFFF_FFFF)
                cnt_reg <= cnt_reg + 32'd1;
        end

        assign cnt_vec[gi] = cnt_reg;
    end

    assign bus.out_cf      = cf_reg;
    assign bus.out_tag     = tag_reg;
    assign bus.out_index   = idx_reg;
    assign bus.out_blockid = bid_reg;
    assign proto_err       = proto_err_reg;
    assign cnt_cf0         = cnt_vec[0];
    assign cnt_cf1         = cnt_vec[1];
    assign cnt_cf2         = cnt_vec[2];

endmodule

// File: tb/tb_fill_line_classifier.sv
// Directed self-checking bench for fill_line_classifier: CF classes, stalls,
// framing errors, back-to-back lines with gaps, and mid-line reset.
module tb_fill_line_classifier;
    import yacc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        proto_err;
    logic [31:0] cnt_cf0, cnt_cf1, cnt_cf2;

    int errors = 0;
    int checks = 0;
    int ov_cycles = 0;
    int exp_cnt [3] = '{0, 0, 0};

    logic [63:0]  beats [8];
    logic [511:0] exp_line;

    fill_line_classifier_if #(.BEAT_W(64), .LINE_W(512), .ADDR_W(32)) bus ();

    fill_line_classifier #(.BEAT_W(64), .LINE_W(512), .ADDR_W(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .proto_err (proto_err),
        .cnt_cf0   (cnt_cf0),
        .cnt_cf1   (cnt_cf1),
        .cnt_cf2   (cnt_cf2)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (bus.out_valid === 1'b1) ov_cycles++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic build_exp();
        for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = beats[k];
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input logic [31:0] addr);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_addr  = addr;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_line(input logic [31:0] addr, input logic last_ok, input int max_gap);
        build_exp();
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_beat(beats[k], (k == 7) ? last_ok : 1'b0, addr);
        end
    endtask

    task automatic deliver();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
        checks++; if (bus.out_data !== 512'd0) begin errors++; $display("FAIL reset_out_data: got %h need 0", bus.out_data); end
        checks++; if (bus.out_cf !== 2'b00) begin errors++; $display("FAIL reset_out_cf: got %b need 00", bus.out_cf); end
        checks++; if ({bus.out_tag, bus.out_index, bus.out_blockid} !== 26'd0) begin errors++; $display("FAIL reset_addr_fields: got %h/%h/%h need 0", bus.out_tag, bus.out_index, bus.out_blockid); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b need 0", proto_err); end
        checks++; if ({cnt_cf0, cnt_cf1, cnt_cf2} !== 96'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d need 0", cnt_cf0, cnt_cf1, cnt_cf2); end
    endtask

    task automatic test_cf_quarter();
        for (int k = 0; k < 8; k++) beats[k] = (k < 2) ? 64'hDEAD_BEEF_0000_0001 : 64'd0;
        send_line(32'h0000_1A40, 1'b1, 0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL quarter_valid: got %b need 1", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL quarter_in_ready: got %b need 0", bus.in_ready); end
        checks++; if (bus.out_cf !== 2'b10) begin errors++; $display("FAIL quarter_cf: got %b need 10", bus.out_cf); end
        checks++; if (bus.out_tag !== 21'h3) begin errors++; $display("FAIL quarter_tag: got %h need 3", bus.out_tag); end
        checks++; if (bus.out_index !== 3'd2) begin errors++; $display("FAIL quarter_index: got %0d need 2", bus.out_index); end
        checks++; if (bus.out_blockid !== 2'd1) begin errors++; $display("FAIL quarter_blockid: got %0d need 1", bus.out_blockid); end
        checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL quarter_data: got %h need %h", bus.out_data, exp_line); end
        deliver();
        exp_cnt[2]++;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL quarter_valid_drop: got %b need 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL quarter_in_ready_back: got %b need 1", bus.in_ready); end
        checks++; if (cnt_cf2 !== 32'(exp_cnt[2])) begin errors++; $display("FAIL quarter_cnt_cf2: got %0d need %0d", cnt_cf2, exp_cnt[2]); end
    endtask

    task automatic test_cf_half_none();
        // nonzero beat 0 must not influence CF
        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        beats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        beats[3] = 64'h1;
        send_line(32'h0000_0000, 1'b1, 1);
        checks++; if (bus.out_cf !== 2'b01) begin errors++; $display("FAIL half_cf: got %b need 01", bus.out_cf); end
        checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL half_data: got %h need %h", bus.out_data, exp_line); end
        deliver();
        exp_cnt[1]++;
        checks++; if (cnt_cf1 !== 32'(exp_cnt[1])) begin errors++; $display("FAIL half_cnt_cf1: got %0d need %0d", cnt_cf1, exp_cnt[1]); end

        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        beats[6] = 64'h80;
        send_line(32'h0000_0000, 1'b1, 1);
        checks++; if (bus.out_cf !== 2'b00) begin errors++; $display("FAIL none_cf: got %b need 00", bus.out_cf); end
        deliver();
        exp_cnt[0]++;
        checks++; if (cnt_cf0 !== 32'(exp_cnt[0])) begin errors++; $display("FAIL none_cnt_cf0: got %0d need %0d", cnt_cf0, exp_cnt[0]); end
        checks++; if (cnt_cf2 !== 32'(exp_cnt[2])) begin errors++; $display("FAIL none_cnt_cf2: got %0d need %0d", cnt_cf2, exp_cnt[2]); end
    endtask

    task automatic test_hold_stall();
        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        send_line(32'h1234_5678, 1'b1, 0);
        // offered beat during HOLD must be refused
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hCAFE_F00D_CAFE_F00D;
        bus.in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d: got %b need 1", c, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b need 0", c, bus.in_ready); end
            checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL stall_data c%0d: got %h need %h", c, bus.out_data, exp_line); end
            checks++; if ({bus.out_cf, bus.out_tag, bus.out_index, bus.out_blockid} !== {2'b10, 21'h2468A, 3'd6, 2'd1}) begin
                errors++; $display("FAIL stall_fields c%0d: got cf=%b tag=%h idx=%0d bid=%0d need 10/2468a/6/1", c, bus.out_cf, bus.out_tag, bus.out_index, bus.out_blockid);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        deliver();
        exp_cnt[2]++;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready_back: got %b need 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_drop: got %b need 0", bus.out_valid); end
        checks++; if (cnt_cf2 !== 32'(exp_cnt[2])) begin errors++; $display("FAIL stall_cnt_cf2: got %0d need %0d", cnt_cf2, exp_cnt[2]); end
    endtask

    task automatic test_framing();
        for (int k = 0; k < 5; k++) send_beat(64'h1111_0000 + 64'(k), (k == 4), 32'h0000_1A40);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL early_last_pulse: got %b need 1", proto_err); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_last_valid: got %b need 0", bus.out_valid); end
        tick();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL early_last_pulse_end: got %b need 0", proto_err); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_last_no_out: got %b need 0", bus.out_valid); end
        checks++; if ({cnt_cf0, cnt_cf1, cnt_cf2} !== {32'(exp_cnt[0]), 32'(exp_cnt[1]), 32'(exp_cnt[2])}) begin
            errors++; $display("FAIL early_last_counters: got %0d/%0d/%0d need %0d/%0d/%0d", cnt_cf0, cnt_cf1, cnt_cf2, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end

        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        beats[5] = 64'h5;
        send_line(32'hFFFF_F9C0, 1'b1, 0);
        checks++; if ({bus.out_valid, bus.out_cf} !== {1'b1, 2'b00}) begin errors++; $display("FAIL recover_cf: got valid=%b cf=%b need 1/00", bus.out_valid, bus.out_cf); end
        checks++; if ({bus.out_tag, bus.out_index, bus.out_blockid} !== {21'h1FFFFF, 3'd1, 2'd3}) begin
            errors++; $display("FAIL recover_addr: got %h/%0d/%0d need 1fffff/1/3", bus.out_tag, bus.out_index, bus.out_blockid);
        end
        checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL recover_data: got %h need %h", bus.out_data, exp_line); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL recover_no_err: got %b need 0", proto_err); end
        deliver();
        exp_cnt[0]++;

        // beat 7 without in_last: line still completes, error still flagged
        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        beats[2] = 64'h7;
        send_line(32'h0000_1A40, 1'b0, 0);
        checks++; if ({bus.out_valid, proto_err} !== 2'b11) begin errors++; $display("FAIL missing_last: got valid=%b err=%b need 1/1", bus.out_valid, proto_err); end
        checks++; if (bus.out_cf !== 2'b01) begin errors++; $display("FAIL missing_last_cf: got %b need 01", bus.out_cf); end
        deliver();
        exp_cnt[1]++;
        checks++; if ({cnt_cf0, cnt_cf1} !== {32'(exp_cnt[0]), 32'(exp_cnt[1])}) begin
            errors++; $display("FAIL framing_counters: got %0d/%0d need %0d/%0d", cnt_cf0, cnt_cf1, exp_cnt[0], exp_cnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        int ov_before;
        logic [1:0] exp_cf;
        ov_before = ov_cycles;
        bus.out_ready = 1'b1;
        for (int ln = 0; ln < 3; ln++) begin
            for (int k = 0; k < 8; k++) begin
                beats[k] = {$urandom, $urandom} | 64'h1;
                if ((ln == 1 && k >= 4) || (ln == 2 && k >= 2)) beats[k] = 64'd0;
            end
            if (beats[4] != 0 || beats[5] != 0 || beats[6] != 0 || beats[7] != 0) exp_cf = 2'b00;
            else if (beats[2] != 0 || beats[3] != 0) exp_cf = 2'b01;
            else exp_cf = 2'b10;
            send_line(32'h0000_0100 * ln, 1'b1, 2);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid l%0d: got %b need 1", ln, bus.out_valid); end
            checks++; if (bus.out_cf !== exp_cf) begin errors++; $display("FAIL b2b_cf l%0d: got %b need %b", ln, bus.out_cf, exp_cf); end
            checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL b2b_data l%0d: got %h need %h", ln, bus.out_data, exp_line); end
            checks++; if (bus.out_index !== 3'(ln)) begin errors++; $display("FAIL b2b_index l%0d: got %0d need %0d", ln, bus.out_index, ln); end
            exp_cnt[exp_cf]++;
            tick();
            checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_release l%0d: got valid=%b ready=%b need 0/1", ln, bus.out_valid, bus.in_ready); end
        end
        bus.out_ready = 1'b0;
        checks++; if (ov_cycles - ov_before !== 3) begin errors++; $display("FAIL b2b_valid_cycles: got %0d need 3", ov_cycles - ov_before); end
        checks++; if ({cnt_cf0, cnt_cf1, cnt_cf2} !== {32'(exp_cnt[0]), 32'(exp_cnt[1]), 32'(exp_cnt[2])}) begin
            errors++; $display("FAIL b2b_counters: got %0d/%0d/%0d need %0d/%0d/%0d", cnt_cf0, cnt_cf1, cnt_cf2, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) send_beat(64'hABCD_0000 + 64'(k), 1'b0, 32'h0000_1A40);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h5555;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        exp_cnt = '{0, 0, 0};
        checks++; if ({bus.in_ready, bus.out_valid, proto_err} !== 3'b100) begin errors++; $display("FAIL midreset_ctrl: got ready=%b valid=%b err=%b need 1/0/0", bus.in_ready, bus.out_valid, proto_err); end
        checks++; if (bus.out_data !== 512'd0) begin errors++; $display("FAIL midreset_data: got %h need 0", bus.out_data); end
        checks++; if ({bus.out_cf, bus.out_tag, bus.out_index, bus.out_blockid} !== 28'd0) begin errors++; $display("FAIL midreset_fields: got cf=%b tag=%h idx=%0d bid=%0d need 0", bus.out_cf, bus.out_tag, bus.out_index, bus.out_blockid); end
        checks++; if ({cnt_cf0, cnt_cf1, cnt_cf2} !== 96'd0) begin errors++; $display("FAIL midreset_counters: got %0d/%0d/%0d need 0", cnt_cf0, cnt_cf1, cnt_cf2); end

        for (int k = 0; k < 8; k++) beats[k] = 64'd0;
        beats[0] = 64'hAAAA;
        beats[3] = 64'h9;
        build_exp();
        for (int k = 0; k < 7; k++) send_beat(beats[k], 1'b0, 32'h0000_0840);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fresh_line_early: got %b need 0 after 7 beats", bus.out_valid); end
        send_beat(beats[7], 1'b1, 32'h0000_0840);
        checks++; if ({bus.out_valid, bus.out_cf} !== {1'b1, 2'b01}) begin errors++; $display("FAIL fresh_line_cf: got valid=%b cf=%b need 1/01", bus.out_valid, bus.out_cf); end
        checks++; if ({bus.out_tag, bus.out_index, bus.out_blockid} !== {21'h1, 3'd0, 2'd1}) begin errors++; $display("FAIL fresh_line_addr: got %h/%0d/%0d need 1/0/1", bus.out_tag, bus.out_index, bus.out_blockid); end
        checks++; if (bus.out_data !== exp_line) begin errors++; $display("FAIL fresh_line_data: got %h need %h", bus.out_data, exp_line); end
        deliver();
        checks++; if ({cnt_cf0, cnt_cf1, cnt_cf2} !== {32'd0, 32'd1, 32'd0}) begin errors++; $display("FAIL fresh_line_counters: got %0d/%0d/%0d need 0/1/0", cnt_cf0, cnt_cf1, cnt_cf2); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_cf_quarter();
        test_cf_half_none();
        test_hold_stall();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
